// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RISC-V M-extension multiply/divide unit
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     raw1;
  logic [XLEN-1:0]     mag2;
  logic [2*XLEN-1:0]   acc;
  logic                neg_res;
  logic                neg_rem;
  logic                fast;

  // Operand decode at the request port: signedness, magnitudes, special cases
  logic            sign1, sign2, div_zero, div_ovf, fast_in;
  logic [XLEN-1:0] mag1_in, mag2_in;
  always_comb begin
    sign1    = op1[XLEN-1] & (op != 3'b011) & (op != 3'b101) & (op != 3'b111);
    sign2    = op2[XLEN-1] & ((op == 3'b000) | (op == 3'b001) | (op == 3'b100) | (op == 3'b110));
    mag1_in  = sign1 ? -op1 : op1;
    mag2_in  = sign2 ? -op2 : op2;
    div_zero = (op2 == '0);
    div_ovf  = ~op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    fast_in  = op[2] & (div_zero | div_ovf);
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
  logic [XLEN-1:0]   q_lo, r_hi, quo, rem, fast_res, final_res;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag2} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mag2};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next  = op_q[2] ? div_next : mul_next;
    prod      = neg_res ? -acc_next : acc_next;
    q_lo      = acc_next[XLEN-1:0];
    r_hi      = acc_next[2*XLEN-1:XLEN];
    quo       = neg_res ? -q_lo : q_lo;
    rem       = neg_rem ? -r_hi : r_hi;
    // Zero divisor vs. signed overflow are the only two ways to get here
    if (mag2 == '0) fast_res = op_q[1] ? raw1 : '1;
    else            fast_res = op_q[1] ? '0 : raw1;
    if (fast) final_res = fast_res;
    else begin
      case (op_q)
        3'b000:                   final_res = prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011:   final_res = prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:           final_res = quo;
        default:                  final_res = rem;
      endcase
    end
  end

  // Control FSM with registered handshake outputs; flush beats completion and iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= '0;
      raw1      <= '0;
      mag2      <= '0;
      acc       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      fast      <= 1'b0;
    end else if (flush && state != IDLE) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            op_q     <= op;
            raw1     <= op1;
            mag2     <= mag2_in;
            acc      <= {{XLEN{1'b0}}, mag1_in};
            neg_res  <= sign1 ^ sign2;
            neg_rem  <= sign1;
            fast     <= fast_in;
            // Special cases spend a single cycle in BUSY to keep a uniform result path
            cnt      <= fast_in ? CNT_W'(1) : CNT_W'(XLEN);
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result    <= final_res;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed-vector bench for alu_muldiv (XLEN 32 and 16)
module tb_alu_muldiv;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] op1, op2, result;

  logic        flush_16, in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
  logic [2:0]  op_16;
  logic [15:0] op1_16, op2_16, result_16;

  int nvec = 0;
  int nerr = 0;

  alu_muldiv #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  alu_muldiv #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .flush(flush_16), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .op(op_16), .op1(op1_16), .op2(op2_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
    .result(result_16), .busy(busy_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request, wait for out_valid; returns edges after accept and whether in_ready stayed low
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit low);
    @(negedge clk);
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, out_valid, 1'b0);
    check({tag, "_rdy_back"}, in_ready, 1'b1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit low;
    issue(o, a, b, lat, low);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp);
    check({tag, "_rdy_low"}, low, 1'b1);
    consume(tag);
  endtask

  initial begin
    int lat;
    bit low;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; op1 = '0; op2 = '0;
    flush_16 = 1'b0; in_valid_16 = 1'b0; out_ready_16 = 1'b0;
    op_16 = '0; op1_16 = '0; op2_16 = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 32'h0);
    rst = 1'b0;

    // Multiply
    do_op("mul_7xm3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32);
    do_op("mulh_min",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32);
    do_op("mulhsu_min",    3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 32);
    do_op("mulhu_min",     3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 32);
    do_op("mul_min",       3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 32);
    do_op("mulh_m1m1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32);
    // Divide
    do_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
    do_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
    do_op("div_7_m2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32);
    do_op("rem_7_m2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32);
    do_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       32);
    do_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        32);
    // Fast path
    do_op("div_by0",       3'b100, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
    do_op("remu_by0",      3'b111, 32'h1234,     32'h0,        32'h00001234, 1);
    do_op("divu_by0",      3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1);
    do_op("rem_neg_by0",   3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1);
    do_op("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Backpressure: result held, new request ignored until after the drain cycle
    issue(3'b101, 32'd100, 32'd7, lat, low);
    check("bp_first_res", result, 32'd14);
    @(negedge clk);
    op = 3'b000; op1 = 32'd3; op2 = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_vld", out_valid, 1'b1);
      check("bp_hold_res", result, 32'd14);
      check("bp_hold_rdy", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_drain_vld", out_valid, 1'b0);
    check("bp_drain_rdy", in_ready, 1'b1);
    check("bp_keep_res", result, 32'd14);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accept", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_lat", lat, 32);
    check("bp_next_res", result, 32'd9);
    consume("bp_next");

    // Flush during the tenth divide iteration
    @(negedge clk);
    op = 3'b100; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_vld", out_valid, 1'b0);
    check("flush_rdy", in_ready, 1'b1);
    check("flush_busy", busy, 1'b0);
    // flush while idle blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_rdy", in_ready, 1'b1);
    check("flush_idle_busy", busy, 1'b0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    op = 3'b000; op1 = 32'd5; op2 = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", in_ready, 1'b1);
    check("arst_vld", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_res", result, 32'h0);
    #1 rst = 1'b0;
    do_op("mulhu_ones", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);

    // XLEN = 16 instance
    @(negedge clk);
    op_16 = 3'b000; op1_16 = 16'h00FF; op2_16 = 16'h0101; in_valid_16 = 1'b1;
    @(posedge clk); #1;
    in_valid_16 = 1'b0;
    lat = 0;
    while (!out_valid_16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("x16_mul_lat", lat, 16);
    check("x16_mul_res", result_16, 16'hFFFF);
    out_ready_16 = 1'b1;
    @(posedge clk); #1;
    out_ready_16 = 1'b0;
    check("x16_rdy_back", in_ready_16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
